// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - in-order instruction prefetch queue with redirect flush
// Optional fetch/drop statistics ports and counters: PREFETCH_STATS_EN
module fetch_prefetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        StallD,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRspValid,
    input  logic [31:0] ImemRspData,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        InstrValidF
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] DropCount
`endif
);
    localparam int QW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [IW-1:0] ILAST = IW'(MAX_OUTSTANDING - 1);
    localparam logic [31:0]   NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
    state_t state, state_nxt;

    logic [31:0]   q_instr     [DEPTH];
    logic [31:0]   q_pc        [DEPTH];
    logic [31:0]   inflight_pc [MAX_OUTSTANDING];
    logic [QW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [IW-1:0] if_wr, if_rd;
    logic [31:0]   fetch_pc;
    logic [OW-1:0] outstanding, drop, drop_redirect;
    logic [OW:0]   pending;
    logic [CW:0]   in_use;
    logic          can_issue, issue, enq, deq, rsp_drop, rsp_take, rsp_counted;

    assign in_use    = (CW+1)'(count) + (CW+1)'(outstanding);
    assign can_issue = (in_use < (CW+1)'(DEPTH)) && (outstanding < OW'(MAX_OUTSTANDING));
    assign issue     = ImemReq && ImemGnt;

    // Responses arriving with nothing in flight are stale (e.g. from before a reset) and ignored.
    assign rsp_drop  = ImemRspValid && !Redirect && (drop != '0);
    assign rsp_take  = ImemRspValid && !Redirect && (drop == '0) && (outstanding != '0)
                       && (state == RUN);
    assign enq       = rsp_take;
    assign deq       = InstrValidF && !StallD && !Redirect;

    assign pending       = (OW+1)'(outstanding) + (OW+1)'(drop);
    assign rsp_counted   = ImemRspValid && (pending != '0);
    assign drop_redirect = OW'(pending - (OW+1)'(rsp_counted));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ImemReq   = 1'b0;
        case (state)
            BOOT:  state_nxt = RUN;
            RUN:   ImemReq = can_issue && !Redirect;
            FLUSH: if (rsp_drop && drop == OW'(1)) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
        if (Redirect) state_nxt = (drop_redirect != '0) ? FLUSH : RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            if_wr       <= '0;
            if_rd       <= '0;
        end else if (Redirect) begin
            // In-flight requests become drops; the in-flight PC FIFO restarts empty.
            fetch_pc    <= RedirectPC & 32'hFFFF_FFFC;
            outstanding <= '0;
            drop        <= drop_redirect;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            if_wr       <= '0;
            if_rd       <= '0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
                if_wr    <= (if_wr == ILAST) ? '0 : if_wr + IW'(1);
            end
            if (rsp_take) if_rd <= (if_rd == ILAST) ? '0 : if_rd + IW'(1);
            if (rsp_drop) drop <= drop - OW'(1);
            outstanding <= outstanding + OW'(issue) - OW'(rsp_take);
            if (enq) tail <= tail + QW'(1);
            if (deq) head <= head + QW'(1);
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (issue && !Redirect) inflight_pc[if_wr] <= fetch_pc;
        if (enq) begin
            q_instr[tail] <= ImemRspData;
            q_pc[tail]    <= inflight_pc[if_rd];
        end
    end

    assign ImemAddr    = fetch_pc;
    assign InstrValidF = (count != '0);
    assign InstrF      = InstrValidF ? q_instr[head] : NOP;
    assign PCF         = InstrValidF ? q_pc[head] : 32'h0;
    assign PCPlus4F    = InstrValidF ? q_pc[head] + 32'd4 : 32'h0;

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FetchCount <= '0;
            DropCount  <= '0;
        end else begin
            if (enq) FetchCount <= FetchCount + 32'd1;
            if (rsp_drop || (Redirect && rsp_counted)) DropCount <= DropCount + 32'd1;
        end
    end
`endif

endmodule
